// File: rtl/ntru_pkg.sv
// Shared definitions for the NTRU e-drain block: width helpers, default sizing and FSM encoding.
package ntru_pkg;

  localparam int N_DEF  = 541;
  localparam int Q_DEF  = 2048;
  localparam int M_DEF  = 1;
  localparam int TW_DEF = 16;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int word_count(input int n, input int m);
    return (n + m - 1) / m;
  endfunction

  localparam int QW    = clog2(Q_DEF - 1);
  localparam int WORDS = word_count(N_DEF, M_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ntru_word_fifo.sv
// Two-entry word FIFO between the e RAM read port and the lane unpacker.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ntru_word_fifo #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;
  logic [1:0]   count_d;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);
  assign count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) rd_q <= ~rd_q;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/ntru_e_stream_out.sv
// Drains the NTRU accumulator RAM e onto an AXI4-Stream master, one coefficient per beat.
// Optional clear-on-read of e is enabled by defining NTRU_E_CLEAR_ON_READ_EN.
module ntru_e_stream_out
  import ntru_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int Q  = Q_DEF,
  parameter int M  = M_DEF,
  parameter int TW = TW_DEF,
  localparam int QB     = clog2(Q - 1),
  localparam int NWORDS = word_count(N, M),
  localparam int AW     = (clog2(NWORDS) > 0) ? clog2(NWORDS) : 1,
  localparam int EW     = M * QB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_rd,
  output logic          e_en,
  output logic [AW-1:0] e_addr,
  input  logic [EW-1:0] e_rdata,
  output logic          e_we,
  output logic [EW-1:0] e_wdata,
  output logic [TW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          busy,
  output logic          done
);

  localparam int WAW = (clog2(NWORDS + 1) > 0) ? clog2(NWORDS + 1) : 1;
  localparam int CW  = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int LW  = (clog2(M) > 0) ? clog2(M) : 1;

  state_e         st_q;
  logic [WAW-1:0] wa_q;
  logic [CW-1:0]  c_q;
  logic [LW-1:0]  ln_q;
  logic           inflight_q;
  logic           done_q;

  logic [EW-1:0]  fifo_head;
  logic [1:0]     fifo_count;
  logic           fifo_pop;
  logic           hs;
  logic           last_beat;
  logic           can_read;
  logic           read_ok;
  logic [2:0]     occ;
  logic [QB-1:0]  lane;

  assign m_axis_tvalid = (st_q == ST_RUN) && (fifo_count != 2'd0);
  assign hs            = m_axis_tvalid && m_axis_tready;
  assign last_beat     = (c_q == CW'(N - 1));
  assign fifo_pop      = hs && ((ln_q == LW'(M - 1)) || last_beat);

  // Counting the word leaving this cycle lets the read stream keep up at one word per cycle.
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
  assign can_read = (st_q == ST_RUN) || ((st_q == ST_IDLE) && start_rd);
  assign read_ok  = can_read && (occ < 3'd2) && (wa_q < WAW'(NWORDS));

  ntru_word_fifo #(
    .W (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (st_q == ST_DONE),
    .push_i  (inflight_q),
    .data_i  (e_rdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

`ifdef NTRU_E_CLEAR_ON_READ_EN
  logic          clr_pend_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] clr_addr_q;

  // The RAM is single-port, so the zeroing write takes the port and blocks a read that cycle.
  assign e_en    = read_ok && !clr_pend_q;
  assign e_we    = clr_pend_q;
  assign e_addr  = clr_pend_q ? clr_addr_q : wa_q[AW-1:0];
  assign e_wdata = '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_pend_q <= 1'b0;
      rd_addr_q  <= '0;
      clr_addr_q <= '0;
    end else begin
      clr_pend_q <= inflight_q;
      if (e_en) rd_addr_q <= wa_q[AW-1:0];
      if (inflight_q) clr_addr_q <= rd_addr_q;
    end
  end
`else
  assign e_en    = read_ok;
  assign e_we    = 1'b0;
  assign e_addr  = wa_q[AW-1:0];
  assign e_wdata = '0;
`endif

  always_comb begin
    lane = '0;
    for (int l = 0; l < M; l++) begin
      if (ln_q == LW'(l)) lane = fifo_head[l*QB +: QB];
    end
  end

  assign m_axis_tdata = TW'(lane);
  assign m_axis_tlast = m_axis_tvalid && last_beat;
  assign busy         = (st_q != ST_IDLE);
  assign done         = done_q;

  // Control FSM plus word, lane and coefficient counters; all cleared when the final beat is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= ST_IDLE;
      wa_q       <= '0;
      c_q        <= '0;
      ln_q       <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= e_en;
      done_q     <= 1'b0;
      if (e_en) wa_q <= wa_q + WAW'(1);
      if (hs) begin
        c_q  <= c_q + CW'(1);
        ln_q <= fifo_pop ? '0 : ln_q + LW'(1);
      end
      case (st_q)
        ST_IDLE: if (start_rd) st_q <= ST_RUN;
        ST_RUN: begin
          if (hs && last_beat) begin
            st_q   <= ST_DONE;
            done_q <= 1'b1;
            wa_q   <= '0;
            c_q    <= '0;
            ln_q   <= '0;
          end
        end
        ST_DONE: st_q <= ST_IDLE;
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule
